// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package arb_pkg;

  localparam int NUM_REQ_C = 4;
  localparam int IDX_W_C   = 2;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  // Binary index of the set bit in a one-hot (or all-zero) vector; 0 when empty.
  function automatic logic [IDX_W_C-1:0] onehot_to_idx(input logic [NUM_REQ_C-1:0] oh);
    logic [IDX_W_C-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ_C; i++) begin
      if (oh[i]) idx = idx | IDX_W_C'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters, arbiter and the downstream encoder.
// Latency: n/a (wires only).
// Backpressure: grant_valid/grant_ready handshake; lock exists only with RR_LOCK_EN.
// Modports: slave = arbiter side (drives grant*), master = requester/consumer side.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NUM_REQ_C-1:0] req;
  logic [NUM_REQ_C-1:0] grant;
  logic [IDX_W_C-1:0]   grant_idx;
  logic                 grant_valid;
  logic                 grant_ready;
`ifdef RR_LOCK_EN
  logic                 lock;

  modport slave  (input  req, grant_ready, lock,
                  output grant, grant_idx, grant_valid);
  modport master (output req, grant_ready, lock,
                  input  grant, grant_idx, grant_valid);
`else
  modport slave  (input  req, grant_ready,
                  output grant, grant_idx, grant_valid);
  modport master (output req, grant_ready,
                  input  grant, grant_idx, grant_valid);
`endif

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, ... mod 4.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of req and ptr.
// Ports: req[3:0], ptr[1:0] in; pick[3:0] one-hot (or zero), any_req out.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ_C-1:0] req,
  input  logic [IDX_W_C-1:0]   ptr,
  output logic [NUM_REQ_C-1:0] pick,
  output logic                 any_req
);

  logic [IDX_W_C-1:0] pos;
  logic               found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ_C; i++) begin
      // 2-bit add wraps naturally, giving the mod-4 scan order.
      pos = ptr + IDX_W_C'(i);
      if (!found && req[pos]) begin
        pick[pos] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter, 4 requesters, registered one-hot grant + index. Optional macro: RR_LOCK_EN.
// Latency: 1 cycle req -> grant_valid; back-to-back grants on acceptance with no bubble.
// Backpressure: grant held stable while grant_ready=0; pointer advances only on acceptance.
// Ports: clk, rst (sync, active-high), arb (rr_arbiter4_if.slave: req, grant, grant_idx,
//        grant_valid, grant_ready, and lock when RR_LOCK_EN is defined).
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter4_if.slave   arb
);

  // The encoder downstream is hard-wired to 4 inputs.
  if (NUM_REQ != NUM_REQ_C || IDX_W != IDX_W_C) begin : g_bad_cfg
    $error("rr_arbiter4 supports only NUM_REQ=4, IDX_W=2");
  end

  state_e               state_q, state_d;
  logic [IDX_W_C-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ_C-1:0] grant_q, grant_d;
  logic [IDX_W_C-1:0]   idx_q, idx_d;

  logic [IDX_W_C-1:0]   next_ptr;
  logic [IDX_W_C-1:0]   pick_ptr;
  logic [NUM_REQ_C-1:0] pick;
  logic                 any_req;
  logic                 hold_lock;

  // In GRANT the picker is only consulted at acceptance, where it must already
  // see the rotated pointer; in IDLE it uses the stored pointer.
  assign next_ptr = idx_q + IDX_W_C'(1);
  assign pick_ptr = (state_q == ST_GRANT) ? next_ptr : ptr_q;

  rr_pick u_pick (
    .req     (arb.req),
    .ptr     (pick_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

`ifdef RR_LOCK_EN
  assign hold_lock = arb.lock && arb.req[idx_q];
`else
  assign hold_lock = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          idx_d   = onehot_to_idx(pick);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A locked grantee keeps the grant and the pointer for another beat.
        if (arb.grant_ready && !hold_lock) begin
          ptr_d = next_ptr;
          if (any_req) begin
            grant_d = pick;
            idx_d   = onehot_to_idx(pick);
          end else begin
            grant_d = '0;
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
    end
  end

  assign arb.grant       = grant_q;
  assign arb.grant_idx   = idx_q;
  assign arb.grant_valid = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus randomized traffic
// compared against a requester-index reference model.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic       lk;
  int         cmp_cnt;
  int         mis_cnt;

  // Reference state: pending grantee (-1 = none) and priority pointer.
  int         m_pend;
  int         m_ptr;

  rr_arbiter4_if bus ();

`ifdef RR_LOCK_EN
  assign bus.lock = lk;
`endif

  rr_arbiter4 #(.NUM_REQ(4), .IDX_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    cmp_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scan(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic bit lock_on();
`ifdef RR_LOCK_EN
    return lk;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_pend = -1;
      m_ptr  = 0;
    end else if (m_pend < 0) begin
      m_pend = scan(bus.req, m_ptr);
    end else if (bus.grant_ready) begin
      if (!(lock_on() && bus.req[m_pend])) begin
        m_ptr  = (m_pend + 1) % 4;
        m_pend = scan(bus.req, m_ptr);
      end
    end
  endtask

  // One clock: model follows the sampled inputs, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("grant",       int'(bus.grant),       (m_pend < 0) ? 0 : (1 << m_pend));
    chk("grant_idx",   int'(bus.grant_idx),   (m_pend < 0) ? 0 : m_pend);
    chk("grant_valid", int'(bus.grant_valid), (m_pend < 0) ? 0 : 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.grant_ready = 1'b0;
    lk = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq[5];
    clk = 1'b0;
    cmp_cnt = 0;
    mis_cnt = 0;
    m_pend = -1;
    m_ptr = 0;

    // Reset state, then idle with no requests.
    do_reset();
    for (int i = 0; i < 5; i++) step();

    // All requesting, always ready: 0001,0010,0100,1000,0001 with no bubbles.
    exp_seq = '{1, 2, 4, 8, 1};
    bus.req = 4'b1111;
    bus.grant_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq", int'(bus.grant), exp_seq[i]);
    end

    // Hold under backpressure while req changes, then accept into IDLE.
    do_reset();
    bus.req = 4'b0101;
    step();
    chk("hold_first", int'(bus.grant), 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) bus.req = 4'b0000;
      step();
      chk("hold_grant", int'(bus.grant), 1);
    end
    bus.grant_ready = 1'b1;
    step();
    chk("after_accept_valid", int'(bus.grant_valid), 0);
    bus.grant_ready = 1'b0;

    // Pointer wrap: accept idx 2, then req 0011 -> 0001, then 0010.
    do_reset();
    bus.req = 4'b0100;
    step();
    chk("wrap_pre", int'(bus.grant), 4);
    bus.req = 4'b0011;
    bus.grant_ready = 1'b1;
    step();
    chk("wrap_0", int'(bus.grant), 1);
    step();
    chk("wrap_1", int'(bus.grant), 2);

    // Reset while a grant is pending clears it and resets the pointer.
    do_reset();
    bus.req = 4'b0100;
    step();
    chk("rst_pre", int'(bus.grant), 4);
    rst = 1'b1;
    step();
    chk("rst_mid_grant", int'(bus.grant), 0);
    rst = 1'b0;
    bus.req = 4'b1100;
    step();
    chk("rst_after", int'(bus.grant), 4);

`ifdef RR_LOCK_EN
    // Locked multi-beat transfer stays on requester 1, then rotates to 3.
    do_reset();
    bus.req = 4'b1010;
    lk = 1'b1;
    bus.grant_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock_beat", int'(bus.grant), 2);
    end
    lk = 1'b0;
    step();
    chk("lock_release", int'(bus.grant), 8);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.req = 4'($urandom_range(0, 15));
      bus.grant_ready = ($urandom_range(0, 2) != 0);
      lk = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
